// File: rtl/raster_pkg.sv
// -----------------------------------------------------------------------------
// raster_pkg
// Shared definitions for the triangle raster walker:
//   - default coordinate and edge-accumulator widths
//   - walker FSM state encoding
//   - per-edge coefficient pair {a, b}
//   - edge_inside(): inclusive inside test on three edge values
// -----------------------------------------------------------------------------
package raster_pkg;

    localparam int COORD_W_DEF = 16;
    localparam int ACC_W_DEF   = 2 * COORD_W_DEF + 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_INIT  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } walker_state_e;

    typedef struct packed {
        logic signed [ACC_W_DEF-1:0] a;
        logic signed [ACC_W_DEF-1:0] b;
    } edge_coef_t;

    // A pixel on an edge (value exactly zero) counts as inside, so only the
    // sign bits matter.
    function automatic logic edge_inside(input logic signed [ACC_W_DEF-1:0] e0,
                                         input logic signed [ACC_W_DEF-1:0] e1,
                                         input logic signed [ACC_W_DEF-1:0] e2);
        return !e0[ACC_W_DEF-1] && !e1[ACC_W_DEF-1] && !e2[ACC_W_DEF-1];
    endfunction

endpackage

// File: rtl/edge_origin_eval.sv
// -----------------------------------------------------------------------------
// edge_origin_eval
// Combinational evaluation of the three edge functions at one point:
//   E_i(p) = a_i*(px - vix) + b_i*(py - viy)
// Ports:
//   vx_i, vy_i : the three vertices (signed, COORD_W)
//   coef_i     : edge coefficients {a, b} per edge
//   px_i, py_i : evaluation point
//   e_o        : edge values at the point (signed, ACC_W)
// -----------------------------------------------------------------------------
module edge_origin_eval
    import raster_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic signed [COORD_W-1:0] vx_i   [3],
    input  logic signed [COORD_W-1:0] vy_i   [3],
    input  edge_coef_t                coef_i [3],
    input  logic signed [COORD_W-1:0] px_i,
    input  logic signed [COORD_W-1:0] py_i,
    output logic signed [ACC_W-1:0]   e_o    [3]
);

    logic signed [ACC_W-1:0] dx_s [3];
    logic signed [ACC_W-1:0] dy_s [3];

    // Offsets are widened before subtracting so they cannot wrap; the sum of
    // the two products still fits ACC_W for any COORD_W-bit inputs.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dx_s[i] = ACC_W'(px_i) - ACC_W'(vx_i[i]);
            dy_s[i] = ACC_W'(py_i) - ACC_W'(vy_i[i]);
            e_o[i]  = $signed(coef_i[i].a) * dx_s[i] + $signed(coef_i[i].b) * dy_s[i];
        end
    end

endmodule

// File: rtl/tri_raster_walker.sv
// -----------------------------------------------------------------------------
// tri_raster_walker
// Sequential triangle rasteriser: accepts one triangle per handshake, derives
// edge coefficients and a screen-clipped bounding box, then walks the box
// row-major one pixel per cycle with incremental edge updates, emitting a
// fragment for every covered pixel.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   tri_valid / tri_ready      triangle handshake (ready == walker idle)
//   v0x..v2y                   signed vertices
//   frag_valid / frag_ready    fragment handshake
//   frag_x, frag_y             pixel coordinates
//   frag_e0..frag_e2           edge values at the pixel
//   done                       one-cycle pulse per finished triangle
// Build option:
//   TRI_RASTER_WALKER_BOTH_WINDINGS_EN - when defined, negative-area triangles
//   are flipped and rasterised; otherwise they are back-face culled.
// -----------------------------------------------------------------------------
module tri_raster_walker
    import raster_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEF,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ACC_W    = ACC_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tri_valid,
    output logic                      tri_ready,
    input  logic signed [COORD_W-1:0] v0x,
    input  logic signed [COORD_W-1:0] v0y,
    input  logic signed [COORD_W-1:0] v1x,
    input  logic signed [COORD_W-1:0] v1y,
    input  logic signed [COORD_W-1:0] v2x,
    input  logic signed [COORD_W-1:0] v2y,
    output logic                      frag_valid,
    input  logic                      frag_ready,
    output logic signed [COORD_W-1:0] frag_x,
    output logic signed [COORD_W-1:0] frag_y,
    output logic signed [ACC_W-1:0]   frag_e0,
    output logic signed [ACC_W-1:0]   frag_e1,
    output logic signed [ACC_W-1:0]   frag_e2,
    output logic                      done
);

    localparam logic signed [COORD_W-1:0] ZERO_C = {COORD_W{1'b0}};
    localparam logic signed [ACC_W-1:0]   ZERO_A = {ACC_W{1'b0}};
    localparam logic signed [COORD_W-1:0] ONE_C  = COORD_W'(1);
    localparam logic signed [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H - 1);

    walker_state_e             state_q, state_d;
    logic                      tri_ready_q, done_q, frag_valid_q;
    logic signed [COORD_W-1:0] vx_q [3];
    logic signed [COORD_W-1:0] vy_q [3];
    edge_coef_t                coef_s [3];
    edge_coef_t                coef_q [3];
    edge_coef_t                eval_coef_s [3];
    logic signed [COORD_W-1:0] px_s, py_s;
    logic signed [ACC_W-1:0]   e_s [3];
    logic signed [ACC_W-1:0]   row_q [3];
    logic signed [ACC_W-1:0]   cur_q [3];
    logic signed [ACC_W-1:0]   frag_e_q [3];
    logic signed [COORD_W-1:0] xmin_s, xmax_s, ymin_s, ymax_s;
    logic signed [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
    logic signed [COORD_W-1:0] x_q, y_q, frag_x_q, frag_y_q;
    logic signed [ACC_W-1:0]   area_s;
    logic                      neg_s, wind_cull_s, culled_s;
    logic                      inside_s, stall_s, scan_step_s, load_s, last_s, accept_s;

    function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a,
                                                       input logic signed [COORD_W-1:0] b,
                                                       input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (b < a) ? b : a;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a,
                                                       input logic signed [COORD_W-1:0] b,
                                                       input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (b > a) ? b : a;
        return (c > m) ? c : m;
    endfunction

    // Raw coefficients for edge (vi, vj), j = i+1 mod 3, from the latched vertices.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            coef_s[i].a = ACC_W'(vy_q[i]) - ACC_W'(vy_q[(i + 1) % 3]);
            coef_s[i].b = ACC_W'(vx_q[(i + 1) % 3]) - ACC_W'(vx_q[i]);
        end
    end

    // The single evaluator computes the area (E_0 at v2) in SETUP and the
    // box-corner edge values in INIT, using the already-flipped coefficients.
    always_comb begin
        if (state_q == ST_SETUP) begin
            eval_coef_s = coef_s;
            px_s        = vx_q[2];
            py_s        = vy_q[2];
        end else begin
            eval_coef_s = coef_q;
            px_s        = xmin_q;
            py_s        = ymin_q;
        end
    end

    edge_origin_eval #(
        .COORD_W (COORD_W),
        .ACC_W   (ACC_W)
    ) u_eval (
        .vx_i   (vx_q),
        .vy_i   (vy_q),
        .coef_i (eval_coef_s),
        .px_i   (px_s),
        .py_i   (py_s),
        .e_o    (e_s)
    );

    assign area_s = e_s[0];

    // Bounding box clamped one-sided to the screen, so a triangle entirely
    // off one side yields an empty box; plus the cull decision.
    always_comb begin
        xmin_s = min3(vx_q[0], vx_q[1], vx_q[2]);
        xmax_s = max3(vx_q[0], vx_q[1], vx_q[2]);
        ymin_s = min3(vy_q[0], vy_q[1], vy_q[2]);
        ymax_s = max3(vy_q[0], vy_q[1], vy_q[2]);
        xmin_s = (xmin_s < ZERO_C) ? ZERO_C : xmin_s;
        xmax_s = (xmax_s > X_LAST) ? X_LAST : xmax_s;
        ymin_s = (ymin_s < ZERO_C) ? ZERO_C : ymin_s;
        ymax_s = (ymax_s > Y_LAST) ? Y_LAST : ymax_s;
`ifdef TRI_RASTER_WALKER_BOTH_WINDINGS_EN
        neg_s       = area_s[ACC_W-1];
        wind_cull_s = 1'b0;
`else
        neg_s       = 1'b0;
        wind_cull_s = area_s[ACC_W-1];
`endif
        culled_s = (area_s == ZERO_A) || wind_cull_s || (xmin_s > xmax_s) || (ymin_s > ymax_s);
    end

    assign accept_s    = tri_valid && tri_ready_q;
    assign inside_s    = edge_inside(cur_q[0], cur_q[1], cur_q[2]);
    assign stall_s     = frag_valid_q && !frag_ready;
    assign scan_step_s = (state_q == ST_SCAN) && !stall_s;
    assign load_s      = scan_step_s && inside_s;
    assign last_s      = (x_q == xmax_q) && (y_q == ymax_q);

    // Walker next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = accept_s ? ST_SETUP : ST_IDLE;
            ST_SETUP: state_d = culled_s ? ST_DONE : ST_INIT;
            ST_INIT:  state_d = ST_SCAN;
            ST_SCAN:  state_d = (scan_step_s && last_s) ? ST_DRAIN : ST_SCAN;
            ST_DRAIN: state_d = frag_valid_q ? ST_DRAIN : ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register and the registered tri_ready/done decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tri_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tri_ready_q <= (state_d == ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    // Vertex capture on accept; coefficients (flipped for negative area) and bbox in SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                vx_q[i]   <= ZERO_C;
                vy_q[i]   <= ZERO_C;
                coef_q[i] <= '{a: ZERO_A, b: ZERO_A};
            end
            xmin_q <= ZERO_C;
            xmax_q <= ZERO_C;
            ymin_q <= ZERO_C;
            ymax_q <= ZERO_C;
        end else begin
            if (state_q == ST_IDLE && accept_s) begin
                vx_q[0] <= v0x;
                vy_q[0] <= v0y;
                vx_q[1] <= v1x;
                vy_q[1] <= v1y;
                vx_q[2] <= v2x;
                vy_q[2] <= v2y;
            end
            if (state_q == ST_SETUP) begin
                for (int i = 0; i < 3; i++) begin
                    coef_q[i].a <= neg_s ? -coef_s[i].a : coef_s[i].a;
                    coef_q[i].b <= neg_s ? -coef_s[i].b : coef_s[i].b;
                end
                xmin_q <= xmin_s;
                xmax_q <= xmax_s;
                ymin_q <= ymin_s;
                ymax_q <= ymax_s;
            end
        end
    end

    // Scan position and edge accumulators: seeded in INIT, stepped in SCAN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= ZERO_C;
            y_q <= ZERO_C;
            for (int i = 0; i < 3; i++) begin
                row_q[i] <= ZERO_A;
                cur_q[i] <= ZERO_A;
            end
        end else begin
            case (state_q)
                ST_INIT: begin
                    x_q   <= xmin_q;
                    y_q   <= ymin_q;
                    row_q <= e_s;
                    cur_q <= e_s;
                end
                ST_SCAN: begin
                    if (scan_step_s && !last_s) begin
                        if (x_q < xmax_q) begin
                            x_q <= x_q + ONE_C;
                            for (int i = 0; i < 3; i++) begin
                                cur_q[i] <= cur_q[i] + $signed(coef_q[i].a);
                            end
                        end else begin
                            x_q <= xmin_q;
                            y_q <= y_q + ONE_C;
                            for (int i = 0; i < 3; i++) begin
                                row_q[i] <= row_q[i] + $signed(coef_q[i].b);
                                cur_q[i] <= row_q[i] + $signed(coef_q[i].b);
                            end
                        end
                    end
                end
                default: begin
                    x_q <= x_q;
                    y_q <= y_q;
                end
            endcase
        end
    end

    // Fragment output register: load on an inside pixel, else clear on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frag_valid_q <= 1'b0;
            frag_x_q     <= ZERO_C;
            frag_y_q     <= ZERO_C;
            for (int i = 0; i < 3; i++) begin
                frag_e_q[i] <= ZERO_A;
            end
        end else if (load_s) begin
            frag_valid_q <= 1'b1;
            frag_x_q     <= x_q;
            frag_y_q     <= y_q;
            frag_e_q     <= cur_q;
        end else if (frag_ready) begin
            frag_valid_q <= 1'b0;
        end else begin
            frag_valid_q <= frag_valid_q;
        end
    end

    assign tri_ready  = tri_ready_q;
    assign done       = done_q;
    assign frag_valid = frag_valid_q;
    assign frag_x     = frag_x_q;
    assign frag_y     = frag_y_q;
    assign frag_e0    = frag_e_q[0];
    assign frag_e1    = frag_e_q[1];
    assign frag_e2    = frag_e_q[2];

endmodule

// File: doc/tri_raster_walker.md
# tri_raster_walker

Sequential triangle rasteriser. Accepts one triangle (three screen-space vertices) per handshake, computes the three edge-function coefficients and a screen-clipped bounding box, then walks the box row-major with incremental edge updates. For every covered pixel it emits a fragment carrying the coordinates and the three edge values. The walker sits between the vertex/setup front end and the fragment shading stage, and supersedes the purely combinational per-pixel edge evaluation.

## Interface
- COORD_W, 16: signed vertex/pixel coordinate width (integer pixels)
- SCREEN_W, 640: screen width; x is clipped to [0, SCREEN_W-1]
- SCREEN_H, 480: screen height; y is clipped to [0, SCREEN_H-1]
- ACC_W, 2*COORD_W+2: signed edge accumulator width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tri_valid  in  1  triangle offered
- tri_ready  out  1  walker idle; accepts a triangle
- v0x, v0y, v1x, v1y, v2x, v2y  in  COORD_W each  signed vertices
- frag_valid  out  1  fragment held on outputs
- frag_ready  in  1  downstream accepts fragment
- frag_x, frag_y  out  COORD_W  pixel coordinates
- frag_e0, frag_e1, frag_e2  out  ACC_W  edge values at the pixel
- done  out  1  one-cycle pulse when a triangle finishes, including culled triangles

## Operation
- Edge i uses vertex pair (vi, vj), j=(i+1)%3:
  - a_i = viy - vjy, b_i = vjx - vix, all sign-extended to ACC_W.
  - E_i(p) = a_i*(px - vix) + b_i*(py - viy).
- Area = E_0(v2). A pixel is inside iff E_0, E_1, E_2 are all >= 0, so pixels on an edge are inclusive.
- Area == 0: degenerate, culled. Area < 0: handled per Configuration.
- Bounding box is the vertex min/max, clamped to the screen. If xmin > xmax or ymin > ymax after clamping, the triangle is culled.
- FSM:
  - IDLE: tri_ready=1. Moves to SETUP on tri_valid && tri_ready; vertices are registered.
  - SETUP (1 cycle): registers a, b, area and the clamped bbox. Moves to DONE if culled, else to INIT.
  - INIT (1 cycle): registers E_i at (xmin, ymin) into the row-start and current accumulators. Moves to SCAN.
  - SCAN: evaluates one pixel per cycle.
    - x < xmax: x+1, E += a.
    - End of row (x == xmax, y < ymax): x=xmin, y+1, row-start += b, current = new row-start.
    - After (xmax, ymax) is evaluated: moves to DRAIN.
  - DRAIN: waits until frag_valid == 0, then moves to DONE.
  - DONE (1 cycle): done=1, then returns to IDLE.
- Inside pixels load the output register. SCAN stalls (no step, no load) while frag_valid && !frag_ready. Outside pixels cost one cycle each and produce no output.
- Output register: frag_valid clears on frag_ready when no new inside pixel loads in the same cycle. Accept and load in the same cycle is allowed and gives back-to-back fragments.
- Reset while in any state returns to IDLE at once and discards any in-flight fragment. No done pulse is issued for the discarded triangle.

## Timing
- Reset values:
  - tri_ready=0 while rst_n low, 1 from the first clock after release.
  - frag_valid=0, done=0.
  - frag_x, frag_y, frag_e0..2 = 0.
  - FSM = IDLE.
- Triangle accepted in cycle T: SETUP in T+1, INIT in T+2, first pixel evaluated in T+3. The first fragment is visible from T+4 at the earliest.
- Culled triangle: done asserted in T+2.
- Throughput with frag_ready held at 1: one pixel per cycle over the bbox.
- frag_* outputs are registered and stay stable while frag_valid && !frag_ready.
- done asserts exactly once per accepted triangle. tri_ready stays low from T+1 until the cycle after done.

## Configuration
- TRI_RASTER_WALKER_BOTH_WINDINGS_EN:
  - Defined: when area < 0, SETUP negates all a_i and b_i. The triangle rasterises identically to its reversed-winding twin, and emitted E values are then >= 0.
  - Undefined: area < 0 triangles are culled like degenerate ones (back-face culling).

## Structure
- Shared package raster_pkg holds:
  - COORD_W and ACC_W defaults
  - walker state enum (IDLE, SETUP, INIT, SCAN, DRAIN, DONE)
  - edge coefficient struct {a, b}
- One sub-module: edge_origin_eval. It is combinational and computes the three E_i at a given point from the vertices and coefficients. It is instantiated once, shared by SETUP (area, at v2) and INIT (at the bbox corner).

## Test plan
- Triangle (0,0),(4,0),(0,4), frag_ready=1, screen 8x8:
  - exactly 15 fragments, all satisfying x+y<=4
  - first fragment (0,0) with E=(0,16,0); last fragment (0,4)
  - done after 25 scan cycles plus drain
- Reversed winding (0,0),(0,4),(4,0): macro undefined → 0 fragments, done at T+2. Macro defined → the same 15 fragments.
- Clipping: (-4,-4),(12,-4),(-4,12) on 8x8 → bbox 0..7 by 0..7 and exactly 43 fragments, all satisfying x+y<=8.
- Backpressure: first case with frag_ready low for 5 cycles after the first fragment → outputs held stable, no fragment dropped or duplicated, 15 total.
- Degenerate (0,0),(2,2),(4,4) → 0 fragments, done at T+2, tri_ready back to 1 at T+3.
- rst_n pulsed low mid-SCAN → frag_valid=0 and tri_ready=1 after release, no done pulse. The next triangle then rasterises correctly.
